serial_sub_ctrl: RTL
====================

# serial_sub_ctrl

Bit-serial N-bit subtractor controller that computes `a - b` with a single full-subtractor cell. It processes one bit per clock, LSB first, and carries the borrow between bits in a flip-flop. The cell is built from two `half_sub_behav` instances. The controller provides the operand capture, bit sequencing, borrow storage and start/done handshake that turn the combinational subtractor cells into a multi-bit arithmetic unit. It targets area-constrained datapaths where latency is acceptable.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepted start edge.
- `b`  input  WIDTH  subtrahend; captured on the accepted start edge.
- `busy`  output  1  high while in SHIFT.
- `done`  output  1  one-cycle pulse when the result is valid.
- `diff`  output  WIDTH  result `a - b` modulo 2^WIDTH; held until the next result.
- `borrow_out`  output  1  final borrow; 1 iff `a < b` unsigned; held with `diff`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - on `start=1`, load `a` into `ra` and `b` into `rb`.
  - clear the borrow flop `br`, the bit counter `cnt` and the shift register `sr`.
  - go to SHIFT.
- SHIFT, each cycle:
  - cell inputs are `ra[0]`, `rb[0]`, `br`.
  - `d = ra[0]^rb[0]^br`.
  - `br' = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br)`.
  - `ra` and `rb` shift right by 1.
  - `sr` shifts right with `d` inserted at the MSB.
  - `cnt` increments.
  - when `cnt == WIDTH-1`, go to DONE.
- On the SHIFT→DONE edge, `diff <= {d, sr[WIDTH-1:1]}` and `borrow_out <= br'`.
- DONE: `done=1` for exactly one cycle, then unconditionally back to IDLE.
- `start` is ignored in SHIFT and in DONE; no queuing.
- `a` and `b` may change freely after the accepted start edge.
- Width rules:
  - `cnt` width is `$clog2(WIDTH)`, minimum 1.
  - no sign handling; the result wraps modulo 2^WIDTH.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, and all internal registers 0.
- Start accepted at edge 0:
  - `busy` is high from after edge 0 through edge WIDTH.
  - `done` is high for the cycle after edge WIDTH.
  - state returns to IDLE after edge WIDTH+1.
- Latency is start edge to `done` high = WIDTH cycles.
- Throughput is one operation per WIDTH+2 cycles, because start is not accepted in DONE.
- `diff` and `borrow_out` update only on the SHIFT→DONE edge. They stay stable while `busy=1` on a subsequent operation.
- Reset asserted mid-operation:
  - immediate abort to the reset state.
  - no `done` pulse is produced.
  - the previous `diff` is cleared to 0.
- `start` held high continuously starts a new operation on every IDLE cycle, i.e. every WIDTH+2 cycles.

## Structure
- Shared header `sub_ctrl_defs.vh` holds:
  - state encodings `ST_IDLE=2'd0`, `ST_SHIFT=2'd1`, `ST_DONE=2'd2`.
  - `MAX_WIDTH=32`.
- Sub-module `full_sub_cell` (ports `a`, `b`, `bin`, `diff`, `bout`):
  - two `half_sub_behav` instances plus an OR of their borrows.
  - purely combinational.
  - instantiated once in `serial_sub_ctrl`.
- Controller RTL contains the FSM, operand shift registers, borrow flop, counter and output registers.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start pulse -> `busy` high 8 cycles, `done` 8 cycles after the start edge, diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Then a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
- a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0.
- Start pulsed again during SHIFT and during DONE with different operands -> ignored; result of the first operation only; exactly one `done` pulse.
- Reset asserted 4 cycles into an operation -> `busy`, `done`, `diff`, `borrow_out` all 0 immediately; no `done` pulse afterwards; the next start completes correctly.
- Exhaustive sweep over all 256×256 operand pairs against the `a-b` model -> every diff/borrow_out matches; `done` spacing ≥ WIDTH+2 cycles with `start` held high.

Source files
------------

// File: rtl/serial_sub_ctrl_pkg.sv
// ============================================================================
// serial_sub_ctrl_pkg
// Shared state encodings, width limits and the bit-counter width helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

  // Counter must still be at least one bit wide for the smallest legal WIDTH.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub_ctrl_full_sub_cell.sv
// ============================================================================
// half_sub_behav / full_sub_cell
// One-bit full subtractor built from two half subtractors and an OR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module half_sub_behav (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  always_comb begin
    diff = a ^ b;
    bout = ~a & b;
  end

endmodule

module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_sub_behav u_hs0 (
    .a    (a),
    .b    (b),
    .diff (d1),
    .bout (b1)
  );

  half_sub_behav u_hs1 (
    .a    (d1),
    .b    (bin),
    .diff (diff),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// serial_sub_ctrl
// Bit-serial a - b, LSB first, one full-subtractor cell, start/done handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_sub_cell u_cell (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (br),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
  assign sr_next  = WIDTH'({cell_d, sr} >> 1);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start)    state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra         <= '0;
      rb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            sr  <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          sr  <= sr_next;
          br  <= cell_bout;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff       <= sr_next;
            borrow_out <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
